serial_word_loader: RTL and testbench
=====================================

// Module: serial_word_loader
// PURPOSE
//  Serial-to-parallel front end for the general-purpose register.
//  Assembles a framed serial bit stream into a WIDTH-bit word and optionally checks
//  a trailing even-parity bit.
//  Issues a one-cycle write strobe with the word; o_we/o_d connect directly to the
//  register's i_we/i_d.
//  Bad-parity frames are dropped and flagged.
// PARAMETERS
//  WIDTH      32  data bits per frame; must equal downstream register WIDTH (>=2)
//  MSB_FIRST  1   1: first received bit lands in o_d[WIDTH-1]; 0: lands in o_d[0]
//  PARITY_EN  1   1: one even-parity bit follows the data bits; 0: no parity bit
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_arstn    in   1      reset, asynchronous, active-low
//  i_srstn    in   1      synchronous clear, active-low, same priority rule as downstream
//  i_start    in   1      frame start strobe (single cycle)
//  i_bit_vld  in   1      qualifies i_bit for one cycle
//  i_bit      in   1      serial data/parity bit
//  o_we       out  1      one-cycle write strobe to register
//  o_d        out  WIDTH  assembled word, stable from o_we until the next o_we
//  o_busy     out  1      frame in progress (state != IDLE)
//  o_err      out  1      one-cycle pulse: parity mismatch, frame discarded
// BEHAVIOUR
//  Reset (i_arstn low, async): state=IDLE, bit counter=0, shift reg=0.
//   Outputs: o_we=0, o_err=0, o_busy=0, o_d=0.
//  Priority each edge: i_arstn > i_srstn > i_start > i_bit_vld.
//   i_srstn low gives the same values as async reset, taken at the clock edge.
//  FSM states: IDLE, DATA, PAR.
//   IDLE: i_start -> DATA, cnt=0, shreg=0.
//    i_bit_vld without i_start is ignored.
//   DATA: each i_bit_vld shifts i_bit in (direction per MSB_FIRST) and cnt++.
//    On the bit with cnt==WIDTH-1:
//     PARITY_EN=1 -> PAR.
//     PARITY_EN=0 -> IDLE, word committed.
//   PAR: on i_bit_vld, compare i_bit to the XOR of the WIDTH data bits.
//    Match: word committed, -> IDLE.
//    Mismatch: o_err pulses, o_d unchanged, no o_we, -> IDLE.
//  Commit: at the edge sampling the last bit, o_d <= assembled word, o_we <= 1.
//   o_we is high exactly one cycle and returns to 0 at the next edge.
//   Latency: o_we visible the cycle after the final bit is sampled.
//  i_start in DATA/PAR: current frame aborted silently (no o_we/o_err).
//   Restart immediately: cnt=0, stay/enter DATA.
//   A same-cycle i_bit_vld is NOT counted.
//  i_start in the same cycle as the final bit: abort wins, no commit.
//  Cycles without i_bit_vld inside a frame: state held, no timeout.
//  Back-to-back frames: i_start allowed in the cycle o_we is high.
//   Its frame commits no earlier than WIDTH(+1) valid bits later.
//  Counter width $clog2(WIDTH); cnt never exceeds WIDTH-1.
//  o_busy is combinational from state only; o_we/o_err/o_d are registered.
// STRUCTURE
//  Shared package/include: state encoding localparams (IDLE=2'd0, DATA=2'd1,
//   PAR=2'd2); CNT_W function of WIDTH.
//  Single module, no sub-modules. The parity accumulator is an XOR register
//   updated per data bit, not a reduction at the end.
//  Top-level test wrapper instantiates serial_word_loader feeding the register
//   with the same WIDTH.
// TESTING (WIDTH=8, MSB_FIRST=1, PARITY_EN=1 unless noted)
//  1 start, bits 1,0,1,0,0,1,0,1, parity 0 -> o_d=8'hA5, o_we=1 for 1 cycle,
//    o_err=0, register holds A5
//  2 same data, parity 1 -> o_err 1-cycle pulse, no o_we, o_d keeps previous value
//  3 MSB_FIRST=0, PARITY_EN=0, bits 1,0,0,0,0,0,0,0 -> o_d=8'h01 one cycle after
//    the 8th bit
//  4 i_start after 4 bits, then a full 3C frame -> single o_we with o_d=8'h3C only
//  5 i_arstn pulsed mid-frame (async, between edges) -> all outputs 0 at once;
//    later bits ignored until i_start
//  6 i_srstn low with final parity bit -> no o_we, state IDLE;
//    gapped i_bit_vld (random idle cycles) frame of 8'hFF -> o_we with 8'hFF

Source files
------------

// File: rtl/serial_word_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_loader_pkg
//  Purpose  : Shared definitions for the serial word loader: the state
//             encoding and the bit-counter width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_word_loader_pkg;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_PAR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_IDLE,
        ST_DATA = c_DATA,
        ST_PAR  = c_PAR
    } state_e;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_loader.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_loader
//  Purpose  : Assembles a framed serial bit stream into a WIDTH-bit word,
//             optionally checks a trailing even-parity bit, and issues a
//             one-cycle write strobe with the word for a downstream register.
//  Ports    : i_clk      - clock, rising edge
//             i_arstn    - asynchronous reset, active low
//             i_srstn    - synchronous clear, active low
//             i_start    - frame start strobe (aborts any frame in progress)
//             i_bit_vld  - qualifies i_bit
//             i_bit      - serial data / parity bit
//             o_we       - one-cycle write strobe
//             o_d        - assembled word, held until the next o_we
//             o_busy     - frame in progress
//             o_err      - one-cycle parity-mismatch pulse, frame dropped
//  Revision : 1.0 - initial release
// ============================================================================
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_srstn,
    input  logic             i_start,
    input  logic             i_bit_vld,
    input  logic             i_bit,
    output logic             o_we,
    output logic [WIDTH-1:0] o_d,
    output logic             o_busy,
    output logic             o_err
);

    localparam int               c_CNT_W = cnt_w(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_e             r_state,  w_nxt_state;
    logic [c_CNT_W-1:0] r_cnt,    w_nxt_cnt;
    logic [WIDTH-1:0]   r_shreg,  w_nxt_shreg;
    logic               r_par,    w_nxt_par;
    logic               r_we,     w_nxt_we;
    logic               r_err,    w_nxt_err;
    logic [WIDTH-1:0]   r_d,      w_nxt_d;
    logic [WIDTH-1:0]   w_shift;

    // Shift direction decides which end the first received bit ends up at.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shift = {r_shreg[WIDTH-2:0], i_bit};
    end else begin : g_lsb_first
        assign w_shift = {i_bit, r_shreg[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_shreg <= w_nxt_shreg;
            r_par   <= w_nxt_par;
            r_we    <= w_nxt_we;
            r_err   <= w_nxt_err;
            r_d     <= w_nxt_d;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_shreg = r_shreg;
        w_nxt_par   = r_par;
        w_nxt_we    = 1'b0;
        w_nxt_err   = 1'b0;
        w_nxt_d     = r_d;

        if (!i_srstn) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_shreg = '0;
            w_nxt_par   = 1'b0;
            w_nxt_d     = '0;
        end else if (i_start) begin
            // Start always wins over a same-cycle bit, including the final one.
            w_nxt_state = ST_DATA;
            w_nxt_cnt   = '0;
            w_nxt_shreg = '0;
            w_nxt_par   = 1'b0;
        end else if (i_bit_vld) begin
            case (r_state)
                ST_DATA: begin
                    w_nxt_shreg = w_shift;
                    // Running parity of the data bits, ready when PAR arrives.
                    w_nxt_par   = r_par ^ i_bit;
                    if (r_cnt == c_LAST) begin
                        w_nxt_cnt = '0;
                        if (PARITY_EN != 0) begin
                            w_nxt_state = ST_PAR;
                        end else begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_we    = 1'b1;
                            w_nxt_d     = w_shift;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                ST_PAR: begin
                    w_nxt_state = ST_IDLE;
                    if (i_bit == r_par) begin
                        w_nxt_we = 1'b1;
                        w_nxt_d  = r_shreg;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = r_state;
                end
            endcase
        end
    end

    assign o_we   = r_we;
    assign o_err  = r_err;
    assign o_d    = r_d;
    assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_loader
//  Purpose  : Self-checking bench for serial_word_loader. Two instances share
//             one stimulus stream: A (MSB first, parity) and B (LSB first,
//             no parity). A frame-level model predicts every output per cycle.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_word_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic srstn = 1'b1;
    logic start = 1'b0;
    logic bit_vld = 1'b0;
    logic bit_i = 1'b0;

    logic         a_we, a_busy, a_err;
    logic [W-1:0] a_d;
    logic         b_we, b_busy, b_err;
    logic [W-1:0] b_d;

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(W), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
        .i_clk(clk), .i_arstn(arstn), .i_srstn(srstn), .i_start(start),
        .i_bit_vld(bit_vld), .i_bit(bit_i),
        .o_we(a_we), .o_d(a_d), .o_busy(a_busy), .o_err(a_err)
    );

    serial_word_loader #(.WIDTH(W), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
        .i_clk(clk), .i_arstn(arstn), .i_srstn(srstn), .i_start(start),
        .i_bit_vld(bit_vld), .i_bit(bit_i),
        .o_we(b_we), .o_d(b_d), .o_busy(b_busy), .o_err(b_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int a_we_cnt = 0;

    // Frame-level model: index 0 = instance A, 1 = instance B.
    // m_phase: 0 idle, 1 collecting data bits, 2 awaiting parity bit.
    int         m_phase [2];
    int         m_nb    [2];
    bit [W-1:0] m_bits  [2];
    bit         m_we    [2];
    bit         m_err   [2];
    bit [W-1:0] m_d     [2];
    bit [W-1:0] m_reg   [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [W-1:0] assemble(input bit [W-1:0] bits, input bit msb);
        bit [W-1:0] word = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) word[W-1-i] = bits[i];
            else     word[i]     = bits[i];
        end
        return word;
    endfunction

    function automatic bit even_par(input bit [W-1:0] bits);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += bits[i];
        return bit'(ones % 2);
    endfunction

    task automatic model_clear(input int k, input bit clr_d);
        m_phase[k] = 0;
        m_nb[k]    = 0;
        m_bits[k]  = '0;
        m_we[k]    = 1'b0;
        m_err[k]   = 1'b0;
        if (clr_d) m_d[k] = '0;
    endtask

    task automatic model_step(input int k);
        bit msb = (k == 0);
        bit pen = (k == 0);
        m_we[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (!arstn || !srstn) begin
            model_clear(k, 1'b1);
        end else if (start) begin
            m_phase[k] = 1;
            m_nb[k]    = 0;
            m_bits[k]  = '0;
        end else if (bit_vld) begin
            if (m_phase[k] == 1) begin
                m_bits[k][m_nb[k]] = bit_i;
                m_nb[k]++;
                if (m_nb[k] == W) begin
                    if (pen) begin
                        m_phase[k] = 2;
                    end else begin
                        m_d[k]     = assemble(m_bits[k], msb);
                        m_we[k]    = 1'b1;
                        m_reg[k]   = m_d[k];
                        m_phase[k] = 0;
                    end
                end
            end else if (m_phase[k] == 2) begin
                if (bit_i == even_par(m_bits[k])) begin
                    m_d[k]   = assemble(m_bits[k], msb);
                    m_we[k]  = 1'b1;
                    m_reg[k] = m_d[k];
                end else begin
                    m_err[k] = 1'b1;
                end
                m_phase[k] = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            model_clear(k, 1'b1);
            m_reg[k] = '0;
        end
    end

    always @(negedge arstn) begin
        model_clear(0, 1'b1);
        model_clear(1, 1'b1);
    end

    // Single compare process: every cycle, after the edge settles.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        if (a_we) a_we_cnt++;
        chk("a_we",   a_we,   m_we[0]);
        chk("a_err",  a_err,  m_err[0]);
        chk("a_d",    a_d,    m_d[0]);
        chk("a_busy", a_busy, m_phase[0] != 0);
        chk("b_we",   b_we,   m_we[1]);
        chk("b_err",  b_err,  m_err[1]);
        chk("b_d",    b_d,    m_d[1]);
        chk("b_busy", b_busy, m_phase[1] != 0);
    end

    task automatic step4(input bit st, input bit vld, input bit b, input bit sr);
        @(negedge clk);
        start   = st;
        bit_vld = vld;
        bit_i   = b;
        srstn   = sr;
        @(posedge clk);
        #2;
    endtask

    task automatic step(input bit st, input bit vld, input bit b);
        step4(st, vld, b, 1'b1);
    endtask

    task automatic send_byte_msb(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, v[i]);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("rst_a_d",    a_d,    8'h00);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_b_we",   b_we,   1'b0);
        @(negedge clk);
        arstn = 1'b1;

        // 1: A5 with correct parity
        step(1'b1, 1'b0, 1'b0);
        chk("t1_busy", a_busy, 1'b1);
        send_byte_msb(8'hA5);
        chk("t1_b_d", b_d, 8'hA5);
        step(1'b0, 1'b1, 1'b0);
        chk("t1_we",  a_we,  1'b1);
        chk("t1_d",   a_d,   8'hA5);
        chk("t1_err", a_err, 1'b0);
        chk("t1_model_d", m_d[0], 8'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_we_drop", a_we, 1'b0);
        chk("t1_reg", m_reg[0], 8'hA5);

        // 2: same data, wrong parity
        step(1'b1, 1'b0, 1'b0);
        send_byte_msb(8'hA5);
        step(1'b0, 1'b1, 1'b1);
        chk("t2_err", a_err, 1'b1);
        chk("t2_we",  a_we,  1'b0);
        chk("t2_d",   a_d,   8'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_err_drop", a_err, 1'b0);

        // 3: B sees bits 1,0,...,0 LSB first, no parity
        step(1'b1, 1'b0, 1'b0);
        send_byte_msb(8'h80);
        chk("t3_b_we", b_we, 1'b1);
        chk("t3_b_d",  b_d,  8'h01);
        chk("t3_model_b", m_d[1], 8'h01);

        // 4: abort after 4 bits, then full 3C frame
        a_we_cnt = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        send_byte_msb(8'h3C);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_d", a_d, 8'h3C);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_we_count", a_we_cnt, 1);

        // 5: async reset mid-frame, between edges
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        #1 arstn = 1'b0;
        #1;
        chk("t5_a_d",    a_d,    8'h00);
        chk("t5_a_busy", a_busy, 1'b0);
        chk("t5_b_d",    b_d,    8'h00);
        arstn = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        chk("t5_idle", a_busy, 1'b0);

        // 6: sync clear on the parity bit, then a gapped FF frame
        step(1'b1, 1'b0, 1'b0);
        send_byte_msb(8'h5A);
        step4(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_we",   a_we,   1'b0);
        chk("t6_busy", a_busy, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, (i < 8) ? 1'b1 : 1'b0);
        end
        chk("t6_ff_we", a_we, 1'b1);
        chk("t6_ff_d",  a_d,  8'hFF);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            step4($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
                  1'($urandom_range(0, 1)), $urandom_range(0, 199) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 arstn = 1'b0;
                #1;
                chk("rnd_arst_d", a_d, 8'h00);
                arstn = 1'b1;
            end
        end

        step(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
